// File: rtl/bf_pkg.sv
// Shared opcode/state types and default widths for the Brainfuck CPU sequencer.
package bf_pkg;

    localparam int unsigned RomAwDef  = 8;
    localparam int unsigned RamAwDef  = 6;
    localparam int unsigned DataWDef  = 8;
    localparam int unsigned DepthWDef = 8;

    typedef enum logic [2:0] {
        OpRight = 3'd0,
        OpLeft  = 3'd1,
        OpInc   = 3'd2,
        OpDec   = 3'd3,
        OpOut   = 3'd4,
        OpIn    = 3'd5,
        OpOpen  = 3'd6,
        OpClose = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        StRun      = 3'd0,
        StScanFwd  = 3'd1,
        StScanBack = 3'd2,
        StWaitTx   = 3'd3,
        StWaitRx   = 3'd4,
        StHalt     = 3'd5
    } seq_state_e;

endpackage

// File: rtl/bf_bracket_scan.sv
// Bracket matcher: nesting depth counter, scan direction, and match/overflow/underflow
// detection for the forward and backward ROM scans.
module bf_bracket_scan
    import bf_pkg::*;
#(
    parameter int unsigned DEPTH_W = DepthWDef
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    start_fwd_i,
    input  logic    start_back_i,
    input  logic    scan_en_i,
    input  opcode_e opcode_i,
    input  logic    pc_zero_i,
    output logic    match_o,
    output logic    overflow_o,
    output logic    underflow_o
);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               back_q, back_d;
    logic               nest_in;
    logic               nest_out;

    // Forward scans nest on '[' and unwind on ']'; backward scans swap the roles.
    always_comb begin
        nest_in  = back_q ? (opcode_i == OpClose) : (opcode_i == OpOpen);
        nest_out = back_q ? (opcode_i == OpOpen) : (opcode_i == OpClose);
    end

    assign match_o     = scan_en_i && nest_out && (depth_q == DEPTH_W'(1));
    assign overflow_o  = scan_en_i && nest_in && (depth_q == {DEPTH_W{1'b1}});
    assign underflow_o = (start_back_i && pc_zero_i) ||
                         (scan_en_i && back_q && !match_o && pc_zero_i);

    always_comb begin
        depth_d = depth_q;
        back_d  = back_q;
        if (start_fwd_i) begin
            depth_d = DEPTH_W'(1);
            back_d  = 1'b0;
        end else if (start_back_i) begin
            depth_d = DEPTH_W'(1);
            back_d  = 1'b1;
        end else if (scan_en_i) begin
            if (nest_in) begin
                depth_d = depth_q + DEPTH_W'(1);
            end else if (nest_out) begin
                depth_d = depth_q - DEPTH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            back_q  <= 1'b0;
        end else begin
            depth_q <= depth_d;
            back_q  <= back_d;
        end
    end

endmodule

// File: rtl/bf_exec_sequencer.sv
// Brainfuck instruction sequencer: step-paced RUN state, bracket scans, serial output handshake.
// Optional blocking ',' input over rx valid/ready when BF_EXEC_SEQUENCER_INPUT_EN is defined.
module bf_exec_sequencer
    import bf_pkg::*;
#(
    parameter int unsigned ROM_AW  = RomAwDef,
    parameter int unsigned RAM_AW  = RamAwDef,
    parameter int unsigned DATA_W  = DataWDef,
    parameter int unsigned DEPTH_W = DepthWDef
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_en,
    input  logic [2:0]        opcode,
    input  logic              rom_overrun,
    output logic [ROM_AW-1:0] pc,
    output logic [RAM_AW-1:0] ptr,
    input  logic [DATA_W-1:0] cell_rdata,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
`ifdef BF_EXEC_SEQUENCER_INPUT_EN
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
`endif
    output logic              halted,
    output logic              error
);

    seq_state_e        state_q, state_d;
    logic [ROM_AW-1:0] pc_q, pc_d;
    logic [RAM_AW-1:0] ptr_q, ptr_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;
    logic              err_set;

    opcode_e           op;
    logic              cell_zero;
    logic              run_step;
    logic              start_fwd;
    logic              start_back;
    logic              scan_en;
    logic              scan_match;
    logic              scan_overflow;
    logic              scan_underflow;
    logic [ROM_AW-1:0] pc_inc;
    logic [ROM_AW-1:0] pc_dec;

    assign op         = opcode_e'(opcode);
    assign cell_zero  = (cell_rdata == '0);
    assign pc_inc     = pc_q + ROM_AW'(1);
    assign pc_dec     = pc_q - ROM_AW'(1);
    // Overrun outranks decode, so a step at the program end never executes anything.
    assign run_step   = (state_q == StRun) && step_en && !rom_overrun;
    assign start_fwd  = run_step && (op == OpOpen) && cell_zero;
    assign start_back = run_step && (op == OpClose) && !cell_zero;
    assign scan_en    = (state_q == StScanFwd) || (state_q == StScanBack);

    bf_bracket_scan #(
        .DEPTH_W (DEPTH_W)
    ) u_bracket_scan (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_fwd_i  (start_fwd),
        .start_back_i (start_back),
        .scan_en_i    (scan_en),
        .opcode_i     (op),
        .pc_zero_i    (pc_q == '0),
        .match_o      (scan_match),
        .overflow_o   (scan_overflow),
        .underflow_o  (scan_underflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            pc_q       <= '0;
            ptr_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ptr_q      <= ptr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            halted_q   <= halted_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ptr_d      = ptr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        err_set    = 1'b0;

        unique case (state_q)
            StRun: begin
                if (step_en && rom_overrun) begin
                    state_d = StHalt;
                end else if (run_step) begin
                    unique case (op)
                        OpRight: begin
                            ptr_d = ptr_q + RAM_AW'(1);
                            pc_d  = pc_inc;
                        end
                        OpLeft: begin
                            ptr_d = ptr_q - RAM_AW'(1);
                            pc_d  = pc_inc;
                        end
                        OpInc, OpDec: pc_d = pc_inc;
                        OpOut: begin
                            tx_data_d  = 8'(cell_rdata);
                            tx_valid_d = 1'b1;
                            state_d    = StWaitTx;
                        end
`ifdef BF_EXEC_SEQUENCER_INPUT_EN
                        OpIn: state_d = StWaitRx;
`else
                        OpIn: pc_d = pc_inc;
`endif
                        OpOpen: begin
                            pc_d = pc_inc;
                            if (cell_zero) begin
                                state_d = StScanFwd;
                            end
                        end
                        OpClose: begin
                            if (cell_zero) begin
                                pc_d = pc_inc;
                            end else if (scan_underflow) begin
                                state_d = StHalt;
                                err_set = 1'b1;
                            end else begin
                                pc_d    = pc_dec;
                                state_d = StScanBack;
                            end
                        end
                    endcase
                end
            end
            StScanFwd: begin
                if (rom_overrun || scan_overflow) begin
                    state_d = StHalt;
                    err_set = 1'b1;
                end else begin
                    pc_d = pc_inc;
                    if (scan_match) begin
                        state_d = StRun;
                    end
                end
            end
            StScanBack: begin
                if (scan_overflow || scan_underflow) begin
                    state_d = StHalt;
                    err_set = 1'b1;
                end else if (scan_match) begin
                    pc_d    = pc_inc;
                    state_d = StRun;
                end else begin
                    pc_d = pc_dec;
                end
            end
            StWaitTx: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    pc_d       = pc_inc;
                    state_d    = StRun;
                end
            end
            StWaitRx: begin
`ifdef BF_EXEC_SEQUENCER_INPUT_EN
                if (rx_valid) begin
                    pc_d    = pc_inc;
                    state_d = StRun;
                end
`else
                state_d = StHalt;
`endif
            end
            StHalt: state_d = StHalt;
            default: begin
                state_d = StHalt;
                err_set = 1'b1;
            end
        endcase

        halted_d = (state_d == StHalt);
        error_d  = error_q | err_set;
    end

    // RAM write strobe is combinational so the cell commits on the step edge at the old ptr.
    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = '0;
`ifdef BF_EXEC_SEQUENCER_INPUT_EN
        rx_ready  = 1'b0;
        if (state_q == StWaitRx) begin
            rx_ready = 1'b1;
            if (rx_valid) begin
                ram_we    = 1'b1;
                ram_wdata = DATA_W'(rx_data);
            end
        end
`endif
        if (run_step) begin
            case (op)
                OpInc: begin
                    ram_we    = 1'b1;
                    ram_wdata = cell_rdata + DATA_W'(1);
                end
                OpDec: begin
                    ram_we    = 1'b1;
                    ram_wdata = cell_rdata - DATA_W'(1);
                end
`ifndef BF_EXEC_SEQUENCER_INPUT_EN
                OpIn: begin
                    ram_we    = 1'b1;
                    ram_wdata = '0;
                end
`endif
                default: ram_we = 1'b0;
            endcase
        end
    end

    assign pc       = pc_q;
    assign ptr      = ptr_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign halted   = halted_q;
    assign error    = error_q;

endmodule

// File: doc/bf_exec_sequencer.md
# bf_exec_sequencer

Instruction sequencer for the Brainfuck CPU. It fetches opcodes from the program ROM and drives the data-pointer and cell-write controls into the 64-cell data RAM. It resolves `[`/`]` jumps by scanning the ROM with a depth counter, and hands `.` output characters to the serial transmitter through a valid/ready handshake. It replaces free-running sequencing with an explicit state machine paced by a step tick.

## Interface
- `ROM_AW`, default 8: program ROM address width.
- `RAM_AW`, default 6: data pointer width (64 cells).
- `DATA_W`, default 8: cell width.
- `DEPTH_W`, default 8: bracket nesting counter width.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `step_en`  in  1  one-cycle execute tick from the clock divider.
- `opcode`  in  3  ROM data at `pc`, combinational.
- `rom_overrun`  in  1  `pc` is past the program end.
- `pc`  out  ROM_AW  program counter to ROM.
- `ptr`  out  RAM_AW  data pointer to RAM.
- `cell_rdata`  in  DATA_W  RAM[`ptr`], combinational.
- `ram_we`  out  1  write strobe for RAM[`ptr`].
- `ram_wdata`  out  DATA_W  write data.
- `tx_valid`  out  1  character available.
- `tx_data`  out  8  character.
- `tx_ready`  in  1  transmitter accepts.
- `halted`  out  1  sticky stop.
- `error`  out  1  sticky bracket fault.

## Operation
- Opcodes: 0 `>`, 1 `<`, 2 `+`, 3 `-`, 4 `.`, 5 `,`, 6 `[`, 7 `]`.
- States: RUN, SCAN_FWD, SCAN_BACK, WAIT_TX, WAIT_RX (macro only), HALT.
- RUN, with `step_en`=1:
  - `rom_overrun`=1 goes to HALT. Overrun has priority over decode.
  - `>` / `<`: `ptr` ±1, wrapping mod 2^RAM_AW. `pc`+1.
  - `+` / `-`: `ram_we`=1 for that cycle, `ram_wdata`=`cell_rdata`±1 mod 2^DATA_W. `pc`+1.
  - `.`: latch `tx_data`=`cell_rdata`, go to WAIT_TX.
  - `,`: write 0 to the cell, `pc`+1.
  - `[` with cell==0: depth=1, `pc`+1, go to SCAN_FWD. With cell≠0: `pc`+1.
  - `]` with cell≠0: depth=1, `pc`−1, go to SCAN_BACK. With cell==0: `pc`+1.
- SCAN_FWD runs one ROM address per `clk` and ignores `step_en`:
  - `[` increments depth; `]` decrements depth.
  - A `]` that takes depth to 0 sets `pc`=that address+1 and returns to RUN.
  - Any other opcode: `pc`+1.
  - `rom_overrun` goes to HALT with `error`=1.
- SCAN_BACK runs one ROM address per `clk`:
  - `]` increments depth; `[` decrements depth.
  - A `[` that takes depth to 0 sets `pc`=that address+1 and returns to RUN.
  - Any other opcode: `pc`−1.
  - Needing to go below `pc`=0 goes to HALT with `error`=1.
- Depth overflow (2^DEPTH_W−1 then another increment) goes to HALT with `error`=1.
- WAIT_TX: hold `tx_valid`=1 and stable `tx_data` until `tx_ready`=1 is sampled. Then `pc`+1 and return to RUN.
- HALT is terminal until reset. All strobes are 0 in HALT.

## Timing
- Reset values: `pc`=0, `ptr`=0, `ram_we`=0, `ram_wdata`=0, `tx_valid`=0, `tx_data`=0, `halted`=0, `error`=0. State is RUN.
- `ram_we` is combinational from state, `step_en` and `opcode`, and is asserted in the `step_en` cycle. `ram_wdata` is valid in the same cycle. The RAM commits on that clock edge, at the pre-update `ptr`.
- `pc`, `ptr`, `tx_*`, `halted`, `error` are registered. They update on the edge that ends the `step_en` cycle or the scan cycle.
- `tx_valid` rises 1 cycle after the `.` step. It falls on the edge after the cycle where `tx_valid`&`tx_ready`=1.
- Scan latency is N clk for N opcodes traversed, including the matching bracket.
- `step_en` arriving outside RUN is dropped, not queued.
- Asserting `rst_n`=0 in any state, including mid-scan or WAIT_TX, clears all outputs immediately.

## Configuration
- Macro: `BF_EXEC_SEQUENCER_INPUT_EN`.
- With the macro defined:
  - Adds ports `rx_valid` in 1, `rx_data` in 8, `rx_ready` out 1.
  - `,` enters WAIT_RX and asserts `rx_ready`.
  - On `rx_valid`=1: `ram_we`=1, `ram_wdata`=`rx_data`, `pc`+1, back to RUN.
- Without the macro: no rx ports, and `,` writes 0 in one step.

## Structure
- `bf_pkg` holds:
  - `opcode_e` (3-bit enum of the 8 opcodes).
  - `seq_state_e`.
  - Default width localparams.
- One sub-module, `bf_bracket_scan`, is natural. It contains the depth counter, the direction, and the match, overflow and underflow detection. The main module owns `pc`/`ptr`/tx.

## Test plan
- Program `+++.` at cell 0: `ram_wdata` sequence is 1, 2, 3. Then `tx_valid`=1 with `tx_data`=3. Hold `tx_ready`=0 for 5 clk: outputs stay stable. Raise `tx_ready`: `pc`=4, then overrun gives `halted`=1, `error`=0.
- `[+]` with cell 0: no `ram_we`. `pc` reaches 3 within 3 clk of the `[` step.
- `++[-]`: cell goes 2, 1, 0. The `]` scans back once to `pc`=3. Final `pc`=5, cell=0, `halted`=1.
- `<` at `ptr`=0 gives `ptr`=63. `-` on cell 0 gives `ram_wdata`=255.
- `[[]` with cell 0: forward scan hits overrun, giving `halted`=1, `error`=1. `]` at `pc`=0 with cell 1 gives `error`=1.
- `rst_n` low while in WAIT_TX: `tx_valid`=0 and `pc`=0 without waiting for a clock edge. After release, execution restarts from 0.
